proc_ctrl: RTL and testbench
============================

Name: proc_ctrl

Overview:
- Control unit for the simple bus-based processor; sits directly upstream of the ALU.
- Fetches one instruction word from din.
- Sequences the register file, the A/G registers and the shared 16-bit bus through timesteps T0..T3.
- Drives the ALU's a_ena, g_ena and add_subnot strobes.

Parameters:
- DATA_W, 16, width of din; only din[8:0] is decoded.
- NREG, 8, number of general registers; fixed at 8 because of the 3-bit X/Y fields.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start request; sampled only in T0.
- din  in  DATA_W  instruction word. din[8:6]=opcode, din[5:3]=X, din[2:0]=Y.
- ir_ena  out  1  load the instruction register this cycle.
- reg_in  out  NREG  one-hot write enable for R0..R7.
- reg_out  out  NREG  one-hot bus drive for R0..R7.
- din_out  out  1  drive din onto the bus (immediate).
- a_ena  out  1  load ALU register A from the bus.
- g_ena  out  1  load ALU register G with the ALU result.
- g_out  out  1  drive G onto the bus.
- add_subnot  out  1  ALU op select: 1=add, 0=subtract.
- done  out  1  one-cycle pulse in the last step of each instruction.
- busy  out  1  high in T1..T3.

Behaviour:
- Reset is synchronous and active-high. While rst=1 at an edge:
  - step <= T0 and IR <= 0.
  - Every output is forced to 0 in the reset cycle, including ir_ena (run is ignored).
- Reset mid-instruction aborts the instruction: no done, no further enables, back to T0.
- State: a 2-bit step counter (T0..T3) plus a 9-bit IR. All outputs decode combinationally from step, IR, and run (in T0 only).
- T0: ir_ena = run. If run=1, IR <= din[8:0] and step -> T1. Otherwise stay in T0 with all other outputs 0.
- mv, op 000:
  - T1: reg_out[Y]=1, reg_in[X]=1, done=1.
  - Then -> T0.
- mvi, op 001:
  - T1: din_out=1, reg_in[X]=1, done=1.
  - Then -> T0. During T1, din carries the immediate, not the opcode.
- add, op 010:
  - T1: reg_out[X]=1, a_ena=1.
  - T2: reg_out[Y]=1, g_ena=1, add_subnot=1.
  - T3: g_out=1, reg_in[X]=1, done=1.
  - Then -> T0.
- sub, op 011: identical to add except add_subnot=0 in T2.
- Opcodes 1xx are illegal: T1 has done=1 with every enable 0, then -> T0. No register is modified.
- add_subnot is 0 in every step other than T2 of add.
- Latency, counted from the T0 cycle that accepts run: mv/mvi 2 cycles, add/sub 4 cycles.
- Back-to-back: if run stays high, the next fetch happens in the T0 cycle immediately after done. There is no idle gap beyond T0.
- run is ignored in T1..T3, and din is ignored in T1..T3 except as bus data for mvi.
- Bus exclusivity, which holds in every cycle:
  - At most one of the reg_out bits, din_out and g_out is 1.
  - reg_in and reg_out are each zero or one-hot.
- X==Y is legal.
  - mv Rx,Rx is a no-op write.
  - add Rx,Rx doubles Rx.
  - sub Rx,Rx yields 0.
- busy = (step != T0).

Test Plan:
- Reset: hold rst=1 with run=1 for 2 cycles -> every output 0 and step T0. Release -> ir_ena=1 in the first cycle after release.
- mvi: din=16'h0048 (mvi R1) with run=1, then din=16'h0F00 in T1 -> T1 shows din_out=1, reg_in=8'h02, done=1. No other enables.
- mv: din=16'h000A (mv R1,R2) -> T1 shows reg_out=8'h04, reg_in=8'h02, done=1. Next cycle is T0.
- add: din=16'h008A (add R1,R2) -> sequence below, with done only in T3.
  - T1: reg_out=8'h02, a_ena=1.
  - T2: reg_out=8'h04, g_ena=1, add_subnot=1.
  - T3: g_out=1, reg_in=8'h02, done=1.
- sub back-to-back: din=16'h00CA (sub R1,R2) with run held high -> same sequence as add but add_subnot=0 in T2. ir_ena=1 in the T0 cycle directly after done. A second sub completes 4 cycles later.
- Abort and illegal:
  - Assert rst in T2 of an add -> the next cycle is T0 with all outputs 0, and done is never pulsed.
  - Then din=16'h0100 (op 100) -> T1 shows done=1, with reg_in, reg_out, a_ena and g_ena all 0.

Source files
------------

// File: rtl/proc_ctrl.sv
// Control unit for the bus-based processor: fetches one instruction in T0 and
// sequences register file, A/G registers and the shared bus through T1..T3.
module proc_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic              ir_ena,
  output logic [NREG-1:0]   reg_in,
  output logic [NREG-1:0]   reg_out,
  output logic              din_out,
  output logic              a_ena,
  output logic              g_ena,
  output logic              g_out,
  output logic              add_subnot,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  step_t      step_q, step_d;
  logic [8:0] ir_q;
  logic [2:0] op, x, y;

  // Only din[8:0] is decoded; upper bits are bus data for mvi.
  logic unused_din_hi;
  assign unused_din_hi = ^din[DATA_W-1:9];

  assign op = ir_q[8:6];
  assign x  = ir_q[5:3];
  assign y  = ir_q[2:0];

  function automatic logic [NREG-1:0] sel(input logic [2:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      if (ir_ena) ir_q <= din[8:0];
    end
  end

  // Outputs are gated by rst so the reset cycle itself shows no enables.
  always_comb begin
    step_d     = step_q;
    ir_ena     = 1'b0;
    reg_in     = '0;
    reg_out    = '0;
    din_out    = 1'b0;
    a_ena      = 1'b0;
    g_ena      = 1'b0;
    g_out      = 1'b0;
    add_subnot = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      busy = (step_q != T0);
      case (step_q)
        T0: begin
          ir_ena = run;
          if (run) step_d = T1;
        end
        T1: begin
          case (op)
            OP_MV: begin
              reg_out = sel(y);
              reg_in  = sel(x);
              done    = 1'b1;
              step_d  = T0;
            end
            OP_MVI: begin
              din_out = 1'b1;
              reg_in  = sel(x);
              done    = 1'b1;
              step_d  = T0;
            end
            OP_ADD, OP_SUB: begin
              reg_out = sel(x);
              a_ena   = 1'b1;
              step_d  = T2;
            end
            default: begin
              done   = 1'b1;
              step_d = T0;
            end
          endcase
        end
        T2: begin
          reg_out    = sel(y);
          g_ena      = 1'b1;
          add_subnot = (op == OP_ADD);
          step_d     = T3;
        end
        T3: begin
          g_out  = 1'b1;
          reg_in = sel(x);
          done   = 1'b1;
          step_d = T0;
        end
        default: step_d = T0;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: per-instruction expected-output schedule
// model checked every cycle, plus directed literal checks.
module tb_proc_ctrl;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [15:0] din;
  logic        ir_ena, din_out, a_ena, g_ena, g_out, add_subnot, done, busy;
  logic [7:0]  reg_in, reg_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  proc_ctrl #(.DATA_W(16), .NREG(8)) dut (
    .clk(clk), .rst(rst), .run(run), .din(din),
    .ir_ena(ir_ena), .reg_in(reg_in), .reg_out(reg_out), .din_out(din_out),
    .a_ena(a_ena), .g_ena(g_ena), .g_out(g_out), .add_subnot(add_subnot),
    .done(done), .busy(busy)
  );

  // {ir_ena, reg_in, reg_out, din_out, a_ena, g_ena, g_out, add_subnot, done, busy}
  function automatic logic [23:0] mk(input logic ie, input logic [7:0] ri, input logic [7:0] ro,
                                     input logic dout, input logic a, input logic g, input logic go,
                                     input logic as, input logic dn, input logic bz);
    return {ie, ri, ro, dout, a, g, go, as, dn, bz};
  endfunction

  logic [23:0] dut_vec;
  assign dut_vec = {ir_ena, reg_in, reg_out, din_out, a_ena, g_ena, g_out, add_subnot, done, busy};

  // Model: queue of output vectors still owed by the instruction in flight.
  logic [23:0] sched[$];

  task automatic push_instr(input logic [8:0] w);
    logic [7:0] ox, oy;
    ox = 8'd1 << w[5:3];
    oy = 8'd1 << w[2:0];
    case (w[8:6])
      3'd0: sched.push_back(mk(0, ox, oy, 0, 0, 0, 0, 0, 1, 1));
      3'd1: sched.push_back(mk(0, ox, 8'h00, 1, 0, 0, 0, 0, 1, 1));
      3'd2, 3'd3: begin
        sched.push_back(mk(0, 8'h00, ox, 0, 1, 0, 0, 0, 0, 1));
        sched.push_back(mk(0, 8'h00, oy, 0, 0, 1, 0, (w[8:6] == 3'd2), 0, 1));
        sched.push_back(mk(0, ox, 8'h00, 0, 0, 0, 1, 0, 1, 1));
      end
      default: sched.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    endcase
  endtask

  always @(negedge clk) begin
    logic [23:0] exp_vec;
    if (rst) exp_vec = '0;
    else if (sched.size() == 0) exp_vec = mk(run, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    else exp_vec = sched[0];
    n_cmp++;
    if (dut_vec !== exp_vec) begin
      n_bad++;
      $display("FAIL model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
    end
    n_cmp++;
    if (($countones(reg_out) + din_out + g_out) > 1 || $countones(reg_in) > 1) begin
      n_bad++;
      $display("FAIL bus_excl t=%0t reg_out=%h din_out=%b g_out=%b reg_in=%h required<=1 driver",
               $time, reg_out, din_out, g_out, reg_in);
    end
    if (rst) sched.delete();
    else if (sched.size() != 0) void'(sched.pop_front());
    else if (run) push_instr(din[8:0]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] tbl[6] = '{16'h0009, 16'h0089, 16'h00C9, 16'h01FF, 16'h0077, 16'h0140};

  initial begin
    int cyc;
    rst = 1'b1; run = 1'b1; din = 16'h0048;
    tick(); #1;
    chk("rst_c1_all0", 32'(dut_vec), 32'h0);
    tick(); #1;
    chk("rst_c2_all0", 32'(dut_vec), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // mvi R1
    rst = 1'b0; run = 1'b1; din = 16'h0048; #1;
    chk("rel_ir_ena", 32'(ir_ena), 32'h1);
    tick(); run = 1'b0; din = 16'h0F00; #1;
    chk("mvi_din_out", 32'(din_out), 32'h1);
    chk("mvi_reg_in", 32'(reg_in), 32'h02);
    chk("mvi_done", 32'(done), 32'h1);
    chk("mvi_others", 32'({reg_out, a_ena, g_ena, g_out}), 32'h0);
    tick();

    // mv R1,R2
    run = 1'b1; din = 16'h000A;
    tick(); run = 1'b0; #1;
    chk("mv_reg_out", 32'(reg_out), 32'h04);
    chk("mv_reg_in", 32'(reg_in), 32'h02);
    chk("mv_done", 32'(done), 32'h1);
    tick(); #1;
    chk("mv_back_t0", 32'(busy), 32'h0);

    // add R1,R2
    run = 1'b1; din = 16'h008A;
    tick(); run = 1'b0; #1;
    chk("add_t1", 32'({reg_out, a_ena, done}), 32'({8'h02, 1'b1, 1'b0}));
    tick(); #1;
    chk("add_t2", 32'({reg_out, g_ena, add_subnot, done}), 32'({8'h04, 1'b1, 1'b1, 1'b0}));
    tick(); #1;
    chk("add_t3", 32'({g_out, reg_in, done}), 32'({1'b1, 8'h02, 1'b1}));
    tick();

    // sub R1,R2 back-to-back with run held
    run = 1'b1; din = 16'h00CA;
    tick(); tick(); #1;
    chk("sub_t2_as", 32'({g_ena, add_subnot}), 32'({1'b1, 1'b0}));
    tick(); #1;
    chk("sub_t3_done", 32'(done), 32'h1);
    tick(); #1;
    chk("b2b_ir_ena", 32'(ir_ena), 32'h1);
    cyc = 0;
    do begin tick(); #1; cyc++; end while (!done && cyc < 8);
    chk("sub2_latency", 32'(cyc), 32'd3);
    run = 1'b0;
    tick();

    // abort add in T2
    run = 1'b1; din = 16'h008A;
    tick(); run = 1'b0;
    tick(); rst = 1'b1; #1;
    chk("abort_rst_cycle", 32'(dut_vec), 32'h0);
    tick(); rst = 1'b0; #1;
    chk("abort_next_t0", 32'(dut_vec), 32'h0);
    tick(); #1;
    chk("abort_no_done", 32'(done), 32'h0);

    // illegal op 100
    run = 1'b1; din = 16'h0100;
    tick(); run = 1'b0; #1;
    chk("ill_done", 32'(done), 32'h1);
    chk("ill_enables", 32'({reg_in, reg_out, a_ena, g_ena}), 32'h0);
    tick(); #1;
    chk("ill_back_t0", 32'(busy), 32'h0);

    // X==Y and mixed ops, each issued from T0
    foreach (tbl[i]) begin
      run = 1'b1; din = tbl[i];
      tick(); run = 1'b0;
      cyc = 0;
      while (busy && cyc < 6) begin tick(); cyc++; end
      chk("tbl_finish", 32'(busy), 32'h0);
    end

    // random run/din; schedule model covers every cycle
    for (int k = 0; k < 60; k++) begin
      run = 1'($urandom_range(0, 1));
      din = 16'($urandom);
      rst = ($urandom_range(0, 19) == 0);
      tick();
    end
    rst = 1'b0; run = 1'b0;
    tick(); tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
